// File: rtl/instr_sequencer.sv
// Program store and playback engine: loads an instruction program over AXI-Stream,
// then replays it iter_count times back-to-back toward the experiment FSM.
module instr_sequencer #(
    parameter int INSTR_W      = 16,
    parameter int PROG_DEPTH   = 256,
    parameter int ADDR_W       = $clog2(PROG_DEPTH),
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] load_axis_tdata,
    input  logic               load_axis_tvalid,
    output logic               load_axis_tready,
    input  logic               load_axis_tlast,
    input  logic               clear,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        iter_count,
    output logic [INSTR_W-1:0] instr_axis_tdata,
    output logic               instr_axis_tvalid,
    input  logic               instr_axis_tready,
    output logic               run_trig,
    input  logic               run_done,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W:0]    prog_len,
    output logic [15:0]        iter_done,
    output logic               err_trunc,
    output logic               err_timeout,
    output logic               aborted
);

    localparam int TO_W = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state;
    logic [INSTR_W-1:0] mem [PROG_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0]  rd_nxt;
    logic               prog_valid;
    logic               locked;
    logic               start_q;
    logic               start_rise;
    logic [15:0]        count_q;
    logic [TO_W-1:0]    to_cnt;
    logic               load_accept;
    logic               last_word;

    assign load_axis_tready = (state == IDLE) && !locked && !start && !rst;
    assign load_accept      = load_axis_tready && load_axis_tvalid;
    assign start_rise       = start && !start_q;
    assign rd_nxt           = rd_ptr + ADDR_W'(1);
    assign last_word        = ({1'b0, rd_ptr} == (prog_len - (ADDR_W+1)'(1)));

    // Program store has no reset; prog_valid/prog_len gate every use of it.
    always_ff @(posedge clk) begin
        if (load_accept)
            mem[wr_ptr] <= load_axis_tdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            prog_valid        <= 1'b0;
            locked            <= 1'b0;
            start_q           <= 1'b0;
            count_q           <= '0;
            to_cnt            <= '0;
            instr_axis_tdata  <= '0;
            instr_axis_tvalid <= 1'b0;
            run_trig          <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            prog_len          <= '0;
            iter_done         <= '0;
            err_trunc         <= 1'b0;
            err_timeout       <= 1'b0;
            aborted           <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        if (prog_valid && iter_count != 16'd0) begin
                            count_q           <= iter_count;
                            iter_done         <= '0;
                            aborted           <= 1'b0;
                            rd_ptr            <= '0;
                            run_trig          <= 1'b1;
                            busy              <= 1'b1;
                            instr_axis_tvalid <= 1'b1;
                            instr_axis_tdata  <= mem[0];
                            state             <= ISSUE;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (clear) begin
                        wr_ptr     <= '0;
                        prog_len   <= '0;
                        prog_valid <= 1'b0;
                        locked     <= 1'b0;
                        err_trunc  <= 1'b0;
                    end else if (load_accept) begin
                        wr_ptr     <= wr_ptr + ADDR_W'(1);
                        prog_valid <= 1'b0;
                        if (load_axis_tlast || wr_ptr == ADDR_W'(PROG_DEPTH - 1)) begin
                            prog_len   <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
                            prog_valid <= 1'b1;
                            wr_ptr     <= '0;
                            if (!load_axis_tlast) begin
                                err_trunc <= 1'b1;
                                locked    <= 1'b1;
                            end
                        end
                    end
                end

                ISSUE: begin
                    if (abort) begin
                        instr_axis_tvalid <= 1'b0;
                        run_trig          <= 1'b0;
                        busy              <= 1'b0;
                        aborted           <= 1'b1;
                        done              <= 1'b1;
                        state             <= IDLE;
                    end else if (instr_axis_tvalid && instr_axis_tready) begin
                        if (last_word) begin
                            iter_done <= iter_done + 16'd1;
                            rd_ptr    <= '0;
                            if (iter_done + 16'd1 == count_q) begin
                                instr_axis_tvalid <= 1'b0;
                                to_cnt            <= '0;
                                state             <= DRAIN;
                            end else begin
                                instr_axis_tdata <= mem[0];
                            end
                        end else begin
                            rd_ptr           <= rd_nxt;
                            instr_axis_tdata <= mem[rd_nxt];
                        end
                    end
                end

                DRAIN: begin
                    if (abort) begin
                        run_trig <= 1'b0;
                        busy     <= 1'b0;
                        aborted  <= 1'b1;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else if (run_done || to_cnt == TO_W'(DONE_TIMEOUT - 1)) begin
                        run_trig <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                        if (!run_done)
                            err_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: expected instruction stream is the stored
// program repeated iter_count times, held in a queue and consumed on each handshake.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] load_axis_tdata = '0;
    logic        load_axis_tvalid = 1'b0;
    logic        load_axis_tready;
    logic        load_axis_tlast = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] iter_count = '0;
    logic [15:0] instr_axis_tdata;
    logic        instr_axis_tvalid;
    logic        instr_axis_tready = 1'b0;
    logic        run_trig;
    logic        run_done = 1'b0;
    logic        busy;
    logic        done;
    logic [8:0]  prog_len;
    logic [15:0] iter_done;
    logic        err_trunc;
    logic        err_timeout;
    logic        aborted;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] prog_q[$];
    logic [15:0] exp_q[$];

    instr_sequencer #(.INSTR_W(16), .PROG_DEPTH(256), .DONE_TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst),
        .load_axis_tdata(load_axis_tdata), .load_axis_tvalid(load_axis_tvalid),
        .load_axis_tready(load_axis_tready), .load_axis_tlast(load_axis_tlast),
        .clear(clear), .start(start), .abort(abort), .iter_count(iter_count),
        .instr_axis_tdata(instr_axis_tdata), .instr_axis_tvalid(instr_axis_tvalid),
        .instr_axis_tready(instr_axis_tready), .run_trig(run_trig), .run_done(run_done),
        .busy(busy), .done(done), .prog_len(prog_len), .iter_done(iter_done),
        .err_trunc(err_trunc), .err_timeout(err_timeout), .aborted(aborted)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_prog(input bit with_last);
        for (int i = 0; i < prog_q.size(); i++) begin
            @(negedge clk);
            load_axis_tdata  = prog_q[i];
            load_axis_tvalid = 1'b1;
            load_axis_tlast  = with_last && (i == prog_q.size() - 1);
        end
        @(negedge clk);
        load_axis_tvalid = 1'b0;
        load_axis_tlast  = 1'b0;
    endtask

    // Starts a run and follows the stream; returns at the first negedge after the final word.
    task automatic run_prog(input int iters, input int mode);
        int  cyc;
        bit  rdy;
        bit  prev_stall;
        logic [15:0] prev;
        exp_q.delete();
        for (int p = 0; p < iters; p++)
            foreach (prog_q[k]) exp_q.push_back(prog_q[k]);
        @(negedge clk);
        iter_count = 16'(iters);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (run_trig !== 1'b1) begin n_fail++; $display("FAIL run_trig_start: got %b exp 1", run_trig); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_start: got %b exp 1", busy); end
        n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL aborted_cleared: got %b exp 0", aborted); end
        cyc = 0;
        prev_stall = 1'b0;
        prev = '0;
        while (exp_q.size() > 0 && cyc < 5000) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 2 == 0);
            else                rdy = 1'($urandom_range(0, 1));
            instr_axis_tready = rdy;
            n_checks++; if (instr_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL tvalid_hold: got %b exp 1 (%0d words left)", instr_axis_tvalid, exp_q.size()); end
            n_checks++; if (instr_axis_tdata !== exp_q[0]) begin n_fail++; $display("FAIL word: got %h exp %h", instr_axis_tdata, exp_q[0]); end
            if (prev_stall) begin
                n_checks++; if (instr_axis_tdata !== prev) begin n_fail++; $display("FAIL stall_stable: got %h exp %h", instr_axis_tdata, prev); end
            end
            prev_stall = !rdy;
            prev = instr_axis_tdata;
            if (instr_axis_tvalid === 1'b1 && rdy) void'(exp_q.pop_front());
            cyc++;
            @(negedge clk);
        end
        instr_axis_tready = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_budget: got %0d words left exp 0", exp_q.size()); end
        n_checks++; if (instr_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL tvalid_end: got %b exp 0", instr_axis_tvalid); end
        n_checks++; if (iter_done !== 16'(iters)) begin n_fail++; $display("FAIL iter_done: got %0d exp %0d", iter_done, iters); end
        n_checks++; if (run_trig !== 1'b1) begin n_fail++; $display("FAIL run_trig_drain: got %b exp 1", run_trig); end
    endtask

    task automatic finish_run();
        repeat (3) @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b exp 0", done); end
        run_done = 1'b1;
        @(negedge clk);
        run_done = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b exp 1", done); end
        n_checks++; if (run_trig !== 1'b0) begin n_fail++; $display("FAIL run_trig_off: got %b exp 0", run_trig); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_off: got %b exp 0", busy); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b exp 0", done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({instr_axis_tvalid, run_trig, busy, done, load_axis_tready} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b exp 00000", {instr_axis_tvalid, run_trig, busy, done, load_axis_tready}); end
        n_checks++; if (prog_len !== 9'd0 || iter_done !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got len %0d iter %0d exp 0 0", prog_len, iter_done); end
        n_checks++; if ({err_trunc, err_timeout, aborted} !== 3'b0) begin n_fail++; $display("FAIL reset_flags: got %b exp 000", {err_trunc, err_timeout, aborted}); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (load_axis_tready !== 1'b1) begin n_fail++; $display("FAIL tready_idle: got %b exp 1", load_axis_tready); end
    endtask

    task automatic test_basic();
        prog_q = '{16'h0001, 16'h0008, 16'h0081, 16'h0006};
        load_prog(1'b1);
        n_checks++; if (prog_len !== 9'd4) begin n_fail++; $display("FAIL prog_len_4: got %0d exp 4", prog_len); end
        run_prog(3, 0);
        finish_run();
    endtask

    task automatic test_stall();
        run_prog(3, 1);
        finish_run();
    endtask

    task automatic test_random();
        int len;
        int iters;
        for (int t = 0; t < 3; t++) begin
            len = $urandom_range(1, 8);
            prog_q.delete();
            for (int i = 0; i < len; i++) prog_q.push_back(16'($urandom));
            load_prog(1'b1);
            n_checks++; if (prog_len !== 9'(len)) begin n_fail++; $display("FAIL prog_len_rand: got %0d exp %0d", prog_len, len); end
            iters = $urandom_range(1, 4);
            run_prog(iters, 2);
            finish_run();
        end
        prog_q = '{16'hBEEF};
        load_prog(1'b1);
        run_prog(5, 0);
        finish_run();
    endtask

    task automatic test_abort();
        prog_q = '{16'h0001, 16'h0008, 16'h0081, 16'h0006};
        load_prog(1'b1);
        @(negedge clk);
        iter_count = 16'd3;
        start = 1'b1;
        instr_axis_tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (instr_axis_tdata !== 16'h0008) begin n_fail++; $display("FAIL abort_pos: got %h exp 0008", instr_axis_tdata); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        instr_axis_tready = 1'b0;
        n_checks++; if ({instr_axis_tvalid, run_trig, busy} !== 3'b000) begin n_fail++; $display("FAIL abort_stop: got %b exp 000", {instr_axis_tvalid, run_trig, busy}); end
        n_checks++; if (aborted !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL abort_flags: got aborted %b done %b exp 1 1", aborted, done); end
        n_checks++; if (iter_done !== 16'd1) begin n_fail++; $display("FAIL abort_iter: got %0d exp 1", iter_done); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || aborted !== 1'b1) begin n_fail++; $display("FAIL abort_after: got done %b aborted %b exp 0 1", done, aborted); end
        run_prog(2, 0);
        finish_run();
    endtask

    task automatic test_no_prog();
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            iter_count = (t == 0) ? 16'd0 : 16'd3;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n_checks++; if (run_trig !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL nostart_trig: got trig %b busy %b exp 0 0", run_trig, busy); end
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL nostart_done: got %b exp 1", done); end
            @(negedge clk);
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL nostart_width: got %b exp 0", done); end
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            n_checks++; if (prog_len !== 9'd0) begin n_fail++; $display("FAIL clear_len: got %0d exp 0", prog_len); end
        end
    endtask

    task automatic test_timeout();
        int k;
        prog_q = '{16'h1234, 16'h5678};
        load_prog(1'b1);
        run_prog(2, 0);
        k = 0;
        while (done !== 1'b1 && k < 1100) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (k != 1024) begin n_fail++; $display("FAIL timeout_cycles: got %0d exp 1024", k); end
        n_checks++; if (err_timeout !== 1'b1 || run_trig !== 1'b0) begin n_fail++; $display("FAIL timeout_flags: got err %b trig %b exp 1 0", err_timeout, run_trig); end
    endtask

    task automatic test_trunc();
        prog_q.delete();
        for (int i = 0; i < 256; i++) prog_q.push_back(16'(i * 3));
        load_prog(1'b0);
        n_checks++; if (err_trunc !== 1'b1) begin n_fail++; $display("FAIL trunc_flag: got %b exp 1", err_trunc); end
        n_checks++; if (prog_len !== 9'd256) begin n_fail++; $display("FAIL trunc_len: got %0d exp 256", prog_len); end
        n_checks++; if (load_axis_tready !== 1'b0) begin n_fail++; $display("FAIL trunc_locked: got %b exp 0", load_axis_tready); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++; if (prog_len !== 9'd0 || err_trunc !== 1'b0) begin n_fail++; $display("FAIL trunc_clear: got len %0d err %b exp 0 0", prog_len, err_trunc); end
        n_checks++; if (load_axis_tready !== 1'b1) begin n_fail++; $display("FAIL trunc_unlock: got %b exp 1", load_axis_tready); end
    endtask

    task automatic test_rst_mid();
        prog_q = '{16'h00AA, 16'h00BB, 16'h00CC};
        load_prog(1'b1);
        @(negedge clk);
        iter_count = 16'd4;
        start = 1'b1;
        instr_axis_tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({instr_axis_tvalid, run_trig, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_async: got %b exp 000", {instr_axis_tvalid, run_trig, busy}); end
        @(negedge clk);
        rst = 1'b0;
        instr_axis_tready = 1'b0;
        @(negedge clk);
        n_checks++; if (prog_len !== 9'd0 || instr_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_after: got len %0d tvalid %b exp 0 0", prog_len, instr_axis_tvalid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_abort();
        test_no_prog();
        test_timeout();
        test_trunc();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
